// File: rtl/tb_run_ctrl_pkg.sv
// Shared types for the run controller: FSM states, result codes and the status width.
package tb_run_ctrl_pkg;

  localparam int STATUS_W = 3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RST_HOLD = 2'd1,
    S_RUN      = 2'd2,
    S_DONE     = 2'd3
  } run_state_e;

  typedef enum logic [STATUS_W-1:0] {
    ST_NONE     = 3'd0,
    ST_PASS     = 3'd1,
    ST_FAIL     = 3'd2,
    ST_EXIT_OK  = 3'd3,
    ST_EXIT_ERR = 3'd4,
    ST_TIMEOUT  = 3'd5
  } run_status_e;

endpackage

// File: rtl/tb_run_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module tb_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             core_clk,
  input  logic             core_rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/tb_run_ctrl.sv
// Run controller: holds the DUT in reset, lets it run, and records how the run ended.
//   state    | meaning
//   IDLE     | DUT in reset, waiting for start_i
//   RST_HOLD | DUT reset held for RESET_WAIT_CYCLES cycles
//   RUN      | DUT fetching, cycle counter running, watching flags/watchdog
//   DONE     | DUT frozen out of reset, result held until the next start_i
module tb_run_ctrl
  import tb_run_ctrl_pkg::*;
#(
  parameter int RESET_WAIT_CYCLES = 4,
  parameter int CNT_W             = 32
) (
  input  logic                core_clk,
  input  logic                core_rst_n,
  input  logic                start_i,
  input  logic [CNT_W-1:0]    max_cycles_i,
  input  logic                tests_passed_i,
  input  logic                tests_failed_i,
  input  logic                exit_valid_i,
  input  logic [CNT_W-1:0]    exit_value_i,
  output logic                dut_rst_n_o,
  output logic                fetch_enable_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [STATUS_W-1:0] status_o,
  output logic [CNT_W-1:0]    exit_code_o,
  output logic [CNT_W-1:0]    cycle_cnt_o
);

  // A zero wait still costs one hold cycle, so the last hold count is never negative.
  localparam int HOLD_W = (RESET_WAIT_CYCLES < 2) ? 1 : $clog2(RESET_WAIT_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (RESET_WAIT_CYCLES == 0) ? '0 : HOLD_W'(RESET_WAIT_CYCLES - 1);

  run_state_e       r_state;
  run_status_e      r_status;
  logic [CNT_W-1:0] r_exit_code;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic             r_dut_rst_n;
  logic             r_fetch_en;
  logic             r_busy;
  logic             r_done;

  run_state_e       w_state_nxt;
  run_status_e      w_status_nxt;
  logic [CNT_W-1:0] w_exit_nxt;
  logic             w_restart;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_cycle_cnt;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    w_exit_nxt   = r_exit_code;
    w_restart    = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          w_state_nxt  = S_RST_HOLD;
          w_status_nxt = ST_NONE;
          w_exit_nxt   = '0;
          w_restart    = 1'b1;
        end
      end
      S_RST_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (tests_failed_i) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = ST_FAIL;
        end else if (tests_passed_i) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = ST_PASS;
        end else if (exit_valid_i) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = (exit_value_i == '0) ? ST_EXIT_OK : ST_EXIT_ERR;
          w_exit_nxt   = exit_value_i;
        end else if ((max_cycles_i != '0) && (w_cycle_cnt >= max_cycles_i)) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = ST_TIMEOUT;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered off the next state so they change on the entering edge.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      r_status    <= ST_NONE;
      r_exit_code <= '0;
      r_hold_cnt  <= '0;
      r_dut_rst_n <= 1'b0;
      r_fetch_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_status    <= w_status_nxt;
      r_exit_code <= w_exit_nxt;
      if (w_restart) begin
        r_hold_cnt <= '0;
      end else if (r_state == S_RST_HOLD) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end
      r_dut_rst_n <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DONE);
      r_fetch_en  <= (w_state_nxt == S_RUN);
      r_busy      <= (w_state_nxt == S_RST_HOLD) || (w_state_nxt == S_RUN);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  tb_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_cnt (
    .core_clk   (core_clk),
    .core_rst_n (core_rst_n),
    .clr_i      (w_restart),
    .en_i       (w_cnt_en),
    .cnt_o      (w_cycle_cnt)
  );

  assign dut_rst_n_o    = r_dut_rst_n;
  assign fetch_enable_o = r_fetch_en;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign status_o       = r_status;
  assign exit_code_o    = r_exit_code;
  assign cycle_cnt_o    = w_cycle_cnt;

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Directed bench for tb_run_ctrl; a second narrow instance covers zero hold wait and saturation.
module tb_tb_run_ctrl;

  logic        core_clk;
  logic        core_rst_n;
  logic        start_i;
  logic [31:0] max_cycles_i;
  logic        tests_passed_i;
  logic        tests_failed_i;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;
  logic        dut_rst_n_o;
  logic        fetch_enable_o;
  logic        busy_o;
  logic        done_o;
  logic [2:0]  status_o;
  logic [31:0] exit_code_o;
  logic [31:0] cycle_cnt_o;

  logic [3:0]  zero4;
  logic        s_dut_rst_n_o;
  logic        s_fetch_enable_o;
  logic        s_busy_o;
  logic        s_done_o;
  logic [2:0]  s_status_o;
  logic [3:0]  s_exit_code_o;
  logic [3:0]  s_cycle_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  tb_run_ctrl #(.RESET_WAIT_CYCLES(4), .CNT_W(32)) u_dut (
    .core_clk       (core_clk),
    .core_rst_n     (core_rst_n),
    .start_i        (start_i),
    .max_cycles_i   (max_cycles_i),
    .tests_passed_i (tests_passed_i),
    .tests_failed_i (tests_failed_i),
    .exit_valid_i   (exit_valid_i),
    .exit_value_i   (exit_value_i),
    .dut_rst_n_o    (dut_rst_n_o),
    .fetch_enable_o (fetch_enable_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .status_o       (status_o),
    .exit_code_o    (exit_code_o),
    .cycle_cnt_o    (cycle_cnt_o)
  );

  tb_run_ctrl #(.RESET_WAIT_CYCLES(0), .CNT_W(4)) u_dut_small (
    .core_clk       (core_clk),
    .core_rst_n     (core_rst_n),
    .start_i        (start_i),
    .max_cycles_i   (zero4),
    .tests_passed_i (tests_passed_i),
    .tests_failed_i (tests_failed_i),
    .exit_valid_i   (exit_valid_i),
    .exit_value_i   (exit_value_i[3:0]),
    .dut_rst_n_o    (s_dut_rst_n_o),
    .fetch_enable_o (s_fetch_enable_o),
    .busy_o         (s_busy_o),
    .done_o         (s_done_o),
    .status_o       (s_status_o),
    .exit_code_o    (s_exit_code_o),
    .cycle_cnt_o    (s_cycle_cnt_o)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge core_clk);
      #1;
    end
  endtask

  initial begin
    zero4          = '0;
    core_rst_n     = 1'b0;
    start_i        = 1'b0;
    max_cycles_i   = '0;
    tests_passed_i = 1'b0;
    tests_failed_i = 1'b0;
    exit_valid_i   = 1'b0;
    exit_value_i   = '0;
    #3;
    chk("rst_busy",   busy_o, 0);
    chk("rst_done",   done_o, 0);
    chk("rst_dutrst", dut_rst_n_o, 0);
    chk("rst_fetch",  fetch_enable_o, 0);
    chk("rst_status", status_o, 0);
    chk("rst_cnt",    cycle_cnt_o, 0);
    tick();
    core_rst_n = 1'b1;
    tick();
    chk("idle_busy", busy_o, 0);

    // reset hold timing and pass at cycle 10
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("hold0_busy",   busy_o, 1);
    chk("hold0_dutrst", dut_rst_n_o, 0);
    chk("hold0_fetch",  fetch_enable_o, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("hold_dutrst", dut_rst_n_o, 0);
      chk("hold_busy",   busy_o, 1);
      if (i == 1) chk("w0_fetch", s_fetch_enable_o, 1);
    end
    tick();
    chk("run_dutrst", dut_rst_n_o, 1);
    chk("run_fetch",  fetch_enable_o, 1);
    chk("run_busy",   busy_o, 1);
    chk("run_cnt0",   cycle_cnt_o, 0);
    tick(10);
    chk("run_cnt10",  cycle_cnt_o, 10);
    chk("run_done0",  done_o, 0);
    tests_passed_i = 1'b1;
    tick();
    tests_passed_i = 1'b0;
    chk("pass_done",   done_o, 1);
    chk("pass_status", status_o, 1);
    chk("pass_cnt",    cycle_cnt_o, 10);
    chk("pass_fetch",  fetch_enable_o, 0);
    chk("pass_dutrst", dut_rst_n_o, 1);
    chk("pass_busy",   busy_o, 0);
    tests_failed_i = 1'b1;
    tick();
    tests_failed_i = 1'b0;
    chk("done_hold_status", status_o, 1);
    chk("done_hold_cnt",    cycle_cnt_o, 10);

    // restart from DONE, exit with non-zero code
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("restart_status", status_o, 0);
    chk("restart_cnt",    cycle_cnt_o, 0);
    chk("restart_dutrst", dut_rst_n_o, 0);
    chk("restart_done",   done_o, 0);
    tick(4);
    chk("exit_run_fetch", fetch_enable_o, 1);
    exit_valid_i = 1'b1;
    exit_value_i = 32'h2A;
    tick();
    exit_valid_i = 1'b0;
    exit_value_i = '0;
    chk("exiterr_status", status_o, 4);
    chk("exiterr_code",   exit_code_o, 32'h2A);
    chk("exiterr_done",   done_o, 1);

    // start held high through RUN, exit with zero code
    start_i = 1'b1;
    tick();
    chk("restart2_code", exit_code_o, 0);
    tick(4);
    chk("held_fetch", fetch_enable_o, 1);
    tick(3);
    chk("held_cnt",  cycle_cnt_o, 3);
    chk("held_busy", busy_o, 1);
    chk("held_done", done_o, 0);
    start_i      = 1'b0;
    exit_valid_i = 1'b1;
    tick();
    exit_valid_i = 1'b0;
    chk("exitok_status", status_o, 3);
    chk("exitok_code",   exit_code_o, 0);
    chk("exitok_cnt",    cycle_cnt_o, 3);

    // watchdog at 20
    max_cycles_i = 32'd20;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(24);
    chk("wd_cnt20",   cycle_cnt_o, 20);
    chk("wd_notdone", done_o, 0);
    tick();
    chk("wd_done",   done_o, 1);
    chk("wd_status", status_o, 5);
    chk("wd_cnt",    cycle_cnt_o, 20);
    chk("wd_code",   exit_code_o, 0);

    // fail beats timeout on the same edge
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(24);
    tests_failed_i = 1'b1;
    tick();
    tests_failed_i = 1'b0;
    chk("failwd_status", status_o, 2);
    chk("failwd_cnt",    cycle_cnt_o, 20);

    // lowering the limit mid-run
    max_cycles_i = 32'd100;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(9);
    chk("lim_cnt5", cycle_cnt_o, 5);
    max_cycles_i = 32'd3;
    tick();
    chk("lim_status", status_o, 5);
    chk("lim_cnt",    cycle_cnt_o, 5);
    chk("lim_done",   done_o, 1);
    max_cycles_i = '0;

    // async reset mid-run, then a fresh run
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(10);
    chk("mid_cnt6", cycle_cnt_o, 6);
    #2;
    core_rst_n = 1'b0;
    #1;
    chk("arst_busy",   busy_o, 0);
    chk("arst_fetch",  fetch_enable_o, 0);
    chk("arst_dutrst", dut_rst_n_o, 0);
    chk("arst_done",   done_o, 0);
    chk("arst_status", status_o, 0);
    chk("arst_code",   exit_code_o, 0);
    chk("arst_cnt",    cycle_cnt_o, 0);
    tick();
    core_rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy_o, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    chk("w0_run_fetch", s_fetch_enable_o, 1);
    tick(3);
    chk("fresh_fetch", fetch_enable_o, 1);
    chk("fresh_cnt0",  cycle_cnt_o, 0);
    tick(2);
    chk("fresh_cnt2",  cycle_cnt_o, 2);
    tick(18);
    chk("fresh_cnt20", cycle_cnt_o, 20);
    chk("sat_cnt",     s_cycle_cnt_o, 4'hF);
    chk("sat_done",    s_done_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
